// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory arbiter.
//   arb_state_t    - two-state arbiter FSM encoding
//   TIMEOUT_RDATA  - read data returned on a forced (timed-out) completion
//   idx_width()    - width of a master index for a given master count
package mem_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  localparam logic [31:0] TIMEOUT_RDATA = 32'h0000_0000;

  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin priority select.
// Searches req upward starting one above last_grant, wrapping modulo N,
// and returns the first set position.
// Ports:
//   req        in  N   request vector
//   last_grant in  IW  index of the most recently served requester
//   pick       out IW  selected index (0 when no request)
//   any_req    out 1   at least one request bit set
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic [IW-1:0] pick,
  output logic          any_req
);

  logic found;

  always_comb begin
    pick    = '0;
    found   = 1'b0;
    any_req = |req;
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (int'(last_grant) + k) % N;
      if (!found && req[idx]) begin
        pick  = IW'(idx);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one PicoRV32-style native memory
// port among NUM_MASTERS requesters. One transfer per grant, then priority
// rotates past the master just served.
//
// Optional build macro: ARB_TIMEOUT_EN -- terminates transfers the slave
// never acknowledges after TIMEOUT_CYCLES busy cycles and records the first
// offending address in err/err_addr. Without it, err/err_addr are tied 0.
//
// Ports:
//   clk, resetn                 clock, async active-low reset
//   m_valid/m_instr             per-master request and fetch flag
//   m_addr/m_wdata/m_wstrb      packed per-master fields (32/32/4 bits each)
//   m_ready                     completion pulse to the granted master
//   m_rdata                     read data broadcast to all masters
//   s_valid/s_instr/s_addr/s_wdata/s_wstrb  request to the slave
//   s_ready/s_rdata             slave completion and read data
//   grant_idx                   current / last granted master
//   busy                        high while a transfer is in flight
//   err/err_addr                sticky timeout flag and first timed-out address
//
// state    | meaning
// ---------+---------------------------------------------------------
// ARB_IDLE | no transfer; pick next requester, register grant
// ARB_BUSY | forwarding granted master to slave until ready/abort/timeout
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int  NUM_MASTERS    = 2,
  parameter int  TIMEOUT_CYCLES = 256,
  localparam int IW             = idx_width(NUM_MASTERS)
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [NUM_MASTERS-1:0]    m_valid,
  input  logic [NUM_MASTERS-1:0]    m_instr,
  input  logic [NUM_MASTERS*32-1:0] m_addr,
  input  logic [NUM_MASTERS*32-1:0] m_wdata,
  input  logic [NUM_MASTERS*4-1:0]  m_wstrb,
  output logic [NUM_MASTERS-1:0]    m_ready,
  output logic [31:0]               m_rdata,
  output logic                      s_valid,
  output logic                      s_instr,
  output logic [31:0]               s_addr,
  output logic [31:0]               s_wdata,
  output logic [3:0]                s_wstrb,
  input  logic                      s_ready,
  input  logic [31:0]               s_rdata,
  output logic [IW-1:0]             grant_idx,
  output logic                      busy,
  output logic                      err,
  output logic [31:0]               err_addr
);

  arb_state_t    state_q, state_d;
  logic [IW-1:0] grant_q, last_q;
  logic [IW-1:0] pick;
  logic          any_req;
  logic          grant_load, last_load;

  logic          g_valid;
  logic          g_instr;
  logic [31:0]   g_addr;
  logic [31:0]   g_wdata;
  logic [3:0]    g_wstrb;

  rr_pick #(
    .N (NUM_MASTERS),
    .IW(IW)
  ) u_pick (
    .req       (m_valid),
    .last_grant(last_q),
    .pick      (pick),
    .any_req   (any_req)
  );

  // Granted master's fields; the arbiter relies on masters holding them stable.
  always_comb begin
    g_valid = m_valid[grant_q];
    g_instr = m_instr[grant_q];
    g_addr  = m_addr[int'(grant_q)*32 +: 32];
    g_wdata = m_wdata[int'(grant_q)*32 +: 32];
    g_wstrb = m_wstrb[int'(grant_q)*4 +: 4];
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CW-1:0] cnt_q;
  logic          timeout_hit;
  logic          err_q;
  logic [31:0]   err_addr_q;

  assign timeout_hit = (state_q == ARB_BUSY) && g_valid && !s_ready &&
                       (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q      <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      if (grant_load) begin
        cnt_q <= '0;
      end else if (state_q == ARB_BUSY && !s_ready && !timeout_hit) begin
        cnt_q <= cnt_q + CW'(1);
      end
      if (timeout_hit) begin
        err_q <= 1'b1;
        if (!err_q) err_addr_q <= g_addr;
      end
    end
  end

  assign err      = err_q;
  assign err_addr = err_addr_q;
`else
  assign err      = 1'b0;
  assign err_addr = 32'h0000_0000;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      last_q  <= IW'(NUM_MASTERS - 1);
    end else begin
      state_q <= state_d;
      if (grant_load) grant_q <= pick;
      if (last_load)  last_q  <= grant_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_load = 1'b0;
    last_load  = 1'b0;
    s_valid    = 1'b0;
    s_wstrb    = 4'b0000;
    m_ready    = '0;
    m_rdata    = s_rdata;
    case (state_q)
      ARB_IDLE: begin
        if (any_req) begin
          grant_load = 1'b1;
          state_d    = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        s_valid = g_valid;
        s_wstrb = g_wstrb;
        if (s_ready) begin
          m_ready[grant_q] = 1'b1;
          last_load        = 1'b1;
          state_d          = ARB_IDLE;
        end else if (!g_valid) begin
          // Master withdrew its request: drop the transfer, keep priority.
          state_d = ARB_IDLE;
        end
`ifdef ARB_TIMEOUT_EN
        else if (timeout_hit) begin
          m_ready[grant_q] = 1'b1;
          m_rdata          = TIMEOUT_RDATA;
          s_valid          = 1'b0;
          last_load        = 1'b1;
          state_d          = ARB_IDLE;
        end
`endif
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  assign s_instr   = g_instr;
  assign s_addr    = g_addr;
  assign s_wdata   = g_wdata;
  assign grant_idx = grant_q;
  assign busy      = (state_q == ARB_BUSY);

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int N  = 2;
  localparam int IW = 1;

  logic            clk;
  logic            resetn;
  logic [N-1:0]    m_valid;
  logic [N-1:0]    m_instr;
  logic [N*32-1:0] m_addr;
  logic [N*32-1:0] m_wdata;
  logic [N*4-1:0]  m_wstrb;
  logic [N-1:0]    m_ready;
  logic [31:0]     m_rdata;
  logic            s_valid;
  logic            s_instr;
  logic [31:0]     s_addr;
  logic [31:0]     s_wdata;
  logic [3:0]      s_wstrb;
  logic            s_ready;
  logic [31:0]     s_rdata;
  logic [IW-1:0]   grant_idx;
  logic            busy;
  logic            err;
  logic [31:0]     err_addr;

  int tests;
  int fails;

  mem_arbiter #(
    .NUM_MASTERS   (N),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .m_valid  (m_valid),
    .m_instr  (m_instr),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_wstrb  (m_wstrb),
    .m_ready  (m_ready),
    .m_rdata  (m_rdata),
    .s_valid  (s_valid),
    .s_instr  (s_instr),
    .s_addr   (s_addr),
    .s_wdata  (s_wdata),
    .s_wstrb  (s_wstrb),
    .s_ready  (s_ready),
    .s_rdata  (s_rdata),
    .grant_idx(grant_idx),
    .busy     (busy),
    .err      (err),
    .err_addr (err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    #1;
    tick();
    resetn = 1'b1;
    #1;
  endtask

  initial begin
    int exp_order [4];
    tests   = 0;
    fails   = 0;
    m_valid = '0;
    m_instr = '0;
    m_addr  = '0;
    m_wdata = '0;
    m_wstrb = '0;
    s_ready = 1'b0;
    s_rdata = '0;
    resetn  = 1'b0;
    #12;

    // reset state
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_svalid", 32'(s_valid), 32'd0);
    chk("rst_mready", 32'(m_ready), 32'd0);
    chk("rst_grant", 32'(grant_idx), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_err_addr", err_addr, 32'd0);
    chk("rst_swstrb", 32'(s_wstrb), 32'd0);
    tick();
    resetn = 1'b1;
    #1;

    // single read from master 0
    m_valid        = 2'b01;
    m_addr[31:0]   = 32'h0000_0010;
    m_wstrb[3:0]   = 4'b0000;
    #1;
    chk("rd_c0_svalid", 32'(s_valid), 32'd0);
    tick();
    chk("rd_c1_svalid", 32'(s_valid), 32'd1);
    chk("rd_c1_saddr", s_addr, 32'h0000_0010);
    chk("rd_c1_busy", 32'(busy), 32'd1);
    chk("rd_c1_mready", 32'(m_ready), 32'd0);
    tick();
    s_ready = 1'b1;
    s_rdata = 32'h1234_5678;
    #1;
    chk("rd_c2_mready", 32'(m_ready), 32'h1);
    chk("rd_c2_mrdata", m_rdata, 32'h1234_5678);
    tick();
    s_ready = 1'b0;
    m_valid = 2'b00;
    #1;
    chk("rd_c3_busy", 32'(busy), 32'd0);
    chk("rd_c3_mready", 32'(m_ready), 32'd0);

    // contention: both masters write continuously after reset
    do_reset();
    exp_order = '{0, 1, 0, 1};
    m_wdata[31:0]  = 32'hA5A5_0000;
    m_wdata[63:32] = 32'hA5A5_0001;
    m_addr[31:0]   = 32'h0000_0100;
    m_addr[63:32]  = 32'h0000_0200;
    m_wstrb        = 8'hFF;
    m_valid        = 2'b11;
    for (int t = 0; t < 4; t++) begin
      tick();
      chk($sformatf("cont%0d_grant", t), 32'(grant_idx), 32'(exp_order[t]));
      chk($sformatf("cont%0d_wdata", t), s_wdata, 32'hA5A5_0000 + 32'(exp_order[t]));
      chk($sformatf("cont%0d_wstrb", t), 32'(s_wstrb), 32'hF);
      tick();
      s_ready = 1'b1;
      #1;
      chk($sformatf("cont%0d_mready", t), 32'(m_ready), 32'(1 << exp_order[t]));
      tick();
      s_ready = 1'b0;
      #1;
      chk($sformatf("cont%0d_idle", t), 32'(busy), 32'd0);
    end
    m_valid = 2'b00;
    m_wstrb = '0;

    // byte write from master 1
    m_addr[63:32] = 32'h0001_0004;
    m_wstrb[7:4]  = 4'b0100;
    m_valid       = 2'b10;
    tick();
    chk("bw_grant", 32'(grant_idx), 32'd1);
    chk("bw_swstrb", 32'(s_wstrb), 32'b0100);
    chk("bw_saddr", s_addr, 32'h0001_0004);
    chk("bw_mready_wait", 32'(m_ready), 32'd0);
    tick();
    s_ready = 1'b1;
    #1;
    chk("bw_mready", 32'(m_ready), 32'b10);
    tick();
    s_ready = 1'b0;
    m_valid = 2'b00;
    #1;
    chk("bw_mready_after", 32'(m_ready), 32'd0);
    tick();
    chk("bw_mready_after2", 32'(m_ready), 32'd0);
    chk("bw_idle", 32'(busy), 32'd0);
    m_wstrb = '0;

    // stray ready in IDLE
    s_ready = 1'b1;
    s_rdata = 32'hCAFE_F00D;
    #1;
    chk("stray_mready", 32'(m_ready), 32'd0);
    tick();
    chk("stray_busy", 32'(busy), 32'd0);
    chk("stray_mready2", 32'(m_ready), 32'd0);
    s_ready = 1'b0;

    // reset mid-transfer
    m_valid = 2'b10;
    tick();
    chk("mrst_svalid_pre", 32'(s_valid), 32'd1);
    chk("mrst_grant_pre", 32'(grant_idx), 32'd1);
    s_ready = 1'b1;
    #1;
    resetn = 1'b0;
    #1;
    chk("mrst_svalid", 32'(s_valid), 32'd0);
    chk("mrst_mready", 32'(m_ready), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    s_ready = 1'b0;
    tick();
    resetn  = 1'b1;
    m_valid = 2'b11;
    tick();
    chk("mrst_first_grant", 32'(grant_idx), 32'd0);
    tick();
    s_ready = 1'b1;
    #1;
    chk("mrst_first_mready", 32'(m_ready), 32'b01);
    tick();
    s_ready = 1'b0;
    m_valid = 2'b00;

    // abort: granted master withdraws, priority unchanged (last_grant = 0)
    m_valid = 2'b10;
    tick();
    chk("abort_grant", 32'(grant_idx), 32'd1);
    m_valid = 2'b00;
    #1;
    chk("abort_svalid", 32'(s_valid), 32'd0);
    chk("abort_mready", 32'(m_ready), 32'd0);
    tick();
    chk("abort_idle", 32'(busy), 32'd0);
    m_valid = 2'b11;
    tick();
    chk("abort_next_grant", 32'(grant_idx), 32'd1);
    tick();
    s_ready = 1'b1;
    #1;
    chk("abort_next_mready", 32'(m_ready), 32'b10);
    tick();
    s_ready = 1'b0;
    m_valid = 2'b00;

`ifdef ARB_TIMEOUT_EN
    // timeout: master 0 reads an unmapped address, slave never answers
    m_addr[31:0] = 32'h0004_0000;
    m_wstrb      = '0;
    s_rdata      = 32'hDEAD_BEEF;
    m_valid      = 2'b01;
    tick();
    chk("to_grant", 32'(grant_idx), 32'd0);
    for (int k = 0; k < 6; k++) tick();
    chk("to_wait_mready", 32'(m_ready), 32'd0);
    chk("to_wait_svalid", 32'(s_valid), 32'd1);
    chk("to_wait_err", 32'(err), 32'd0);
    tick();
    chk("to_mready", 32'(m_ready), 32'b01);
    chk("to_mrdata", m_rdata, 32'h0000_0000);
    chk("to_svalid", 32'(s_valid), 32'd0);
    tick();
    m_valid = 2'b00;
    #1;
    chk("to_err", 32'(err), 32'd1);
    chk("to_err_addr", err_addr, 32'h0004_0000);
    chk("to_idle", 32'(busy), 32'd0);
    m_addr[63:32] = 32'h0000_0040;
    m_valid       = 2'b10;
    tick();
    chk("to_after_grant", 32'(grant_idx), 32'd1);
    tick();
    s_ready = 1'b1;
    s_rdata = 32'h0BAD_F00D;
    #1;
    chk("to_after_mready", 32'(m_ready), 32'b10);
    chk("to_after_mrdata", m_rdata, 32'h0BAD_F00D);
    tick();
    s_ready = 1'b0;
    m_valid = 2'b00;
    #1;
    chk("to_err_sticky", 32'(err), 32'd1);
    chk("to_err_addr_held", err_addr, 32'h0004_0000);
`else
    chk("noto_err", 32'(err), 32'd0);
    chk("noto_err_addr", err_addr, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Round-robin arbiter that shares the single-port native memory (valid/ready/addr/wdata/wstrb/rdata, PicoRV32-style) among NUM_MASTERS requesters, e.g. CPU and a DMA/debug loader.
- Sits between the masters and the memory/MMIO slave.
- Holds a grant for exactly one transfer, then rotates priority.
- Optionally terminates transfers the slave never acknowledges, such as unmapped addresses.

Parameters:
- NUM_MASTERS, 2: number of requesters; legal range 2..8.
- TIMEOUT_CYCLES, 256: cycles in BUSY without s_ready before forced termination. Used only with ARB_TIMEOUT_EN; must be ≥ 2.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- m_valid  in  NUM_MASTERS  per-master request; held until the matching m_ready.
- m_instr  in  NUM_MASTERS  per-master instruction-fetch flag.
- m_addr  in  NUM_MASTERS*32  packed; master i occupies bits [32i+31:32i].
- m_wdata  in  NUM_MASTERS*32  packed as m_addr.
- m_wstrb  in  NUM_MASTERS*4  packed; master i occupies bits [4i+3:4i]; all zero means read.
- m_ready  out  NUM_MASTERS  one-cycle completion pulse to the granted master only.
- m_rdata  out  32  read data, broadcast to all masters; valid only when m_ready[i] is high.
- s_valid  out  1  request to the slave.
- s_instr  out  1  instruction-fetch flag to the slave.
- s_addr  out  32  address to the slave.
- s_wdata  out  32  write data to the slave.
- s_wstrb  out  4  byte strobes to the slave.
- s_ready  in  1  slave completion; registered one-cycle pulse.
- s_rdata  in  32  slave read data.
- grant_idx  out  $clog2(NUM_MASTERS)  currently or last granted master.
- busy  out  1  high while in BUSY.
- err  out  1  sticky timeout flag (ARB_TIMEOUT_EN only; otherwise tied 0).
- err_addr  out  32  address of the first timed-out transfer (ARB_TIMEOUT_EN only; otherwise tied 0).

Behaviour:
- Reset (resetn low, async):
  - state=IDLE, grant_idx=0, last_grant=NUM_MASTERS-1, counter=0, err=0, err_addr=0.
  - Consequently s_valid=0, m_ready=0, busy=0.
- States: IDLE, BUSY; grant_idx is a register.
- IDLE:
  - If any m_valid bit is set, select the first set bit searching upward from last_grant+1, wrapping modulo NUM_MASTERS.
  - Register grant_idx and go to BUSY. Arbitration costs one cycle; there is no combinational bypass.
- BUSY, slave-side outputs:
  - s_valid = m_valid[grant_idx].
  - s_addr/s_wdata/s_wstrb/s_instr = the granted master's fields, muxed combinationally.
- Slave-side outputs outside BUSY:
  - s_valid=0; s_addr/s_wdata/s_instr driven from master grant_idx; s_wstrb=0.
- BUSY, completion:
  - m_ready[grant_idx] = s_ready, combinational; all other m_ready bits are 0.
  - m_rdata = s_rdata, combinational pass-through.
  - On s_ready: last_grant<=grant_idx, next state IDLE.
  - The next grant is issued the following cycle; back-to-back transfers therefore occupy one transfer every 3 cycles minimum with a 1-cycle slave.
- Latency: request at cycle 0 → s_valid at cycle 1 → m_ready at cycle 2 with a slave that answers in one cycle.
- Fairness: with all masters requesting continuously, grants cycle 0,1,…,N-1,0 and no master waits more than N-1 transfers.
- Abort: if m_valid[grant_idx] falls in BUSY without s_ready (master reset):
  - return to IDLE; last_grant unchanged; no m_ready.
- s_ready in IDLE is ignored; no m_ready is generated.
- Master contract: address/data/strobes are stable while valid; the arbiter does not latch them.
- Write vs read is carried entirely by the strobes; the arbiter does not interpret them.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle without s_ready.
  - When it reaches TIMEOUT_CYCLES-1 with s_ready still low, that cycle: m_ready[grant_idx]=1, m_rdata=32'h0000_0000, s_valid=0, next state IDLE, last_grant updated.
  - err sets sticky; err_addr captures the granted master's address only if err was 0.
  - err and err_addr clear only on reset.
- Not defined:
  - BUSY waits indefinitely; err and err_addr are tied 0; no counter logic is generated.

Decomposition:
- Package mem_arb_pkg holds:
  - typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t
  - localparam TIMEOUT_RDATA = 32'h0
  - width helper for grant_idx
- One sub-module, rr_pick: combinational round-robin priority select.
  - Inputs: req vector, last_grant.
  - Outputs: pick index, any_req.

Test Plan:
- Single read: master 0 reads 0x0000_0010, slave returns 0x1234_5678 one cycle after s_valid → s_valid at cycle 1, m_ready[0] and m_rdata=0x1234_5678 at cycle 2, m_ready[1]=0 throughout.
- Contention: both masters request at cycle 0 after reset → grant order 0,1,0,1 over four transfers; each master's write (wstrb=4'b1111, wdata=0xA5A5_0000+i) reaches the slave unchanged.
- Byte write: master 1 sends wstrb=4'b0100, addr 0x0001_0004 → s_wstrb=4'b0100, s_addr=0x0001_0004, exactly one m_ready[1] pulse.
- Reset mid-transfer: resetn low while BUSY with s_valid=1 → s_valid, m_ready and busy go 0 immediately (async); after release the first request is granted to master 0.
- Stray ready: s_ready pulsed while IDLE → m_ready stays 0, state stays IDLE.
- Timeout (ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8): master 0 reads 0x0004_0000 and the slave never readies → m_ready[0] pulse with m_rdata=0 eight cycles after grant, err=1, err_addr=0x0004_0000; a following valid access completes normally.
